// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the pipeline: opcodes, widths, decoded-op and issue records.
package cpu_isa_pkg;

    localparam int REG_W  = 2;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int QDEPTH = 2;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    // Only the low four operand bits carry meaning, so that is all the queue keeps.
    typedef struct packed {
        logic [2:0]        opcode;
        logic [3:0]        ad1;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef struct packed {
        logic              use_a;
        logic              use_b;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
        logic [REG_W-1:0]  rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              is_hlt;
    } dec_t;

    typedef struct packed {
        logic              valid;
        logic [2:0]        opcode;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
    } ex_t;

    function automatic logic has_imm(input logic [2:0] op);
        return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO);
    endfunction

    function automatic dec_t decode(input logic [2:0] op, input logic [3:0] ad1);
        dec_t d;
        d = '0;
        case (op)
            OP_HLT: d.is_hlt = 1'b1;
            OP_LDO: begin
                d.rd     = ad1[1:0];
                d.reg_wr = 1'b1;
            end
            OP_LDA: begin
                d.rd     = ad1[1:0];
                d.reg_wr = 1'b1;
                d.mem_rd = 1'b1;
            end
            OP_STO: begin
                d.use_a  = 1'b1;
                d.src_a  = ad1[1:0];
                d.mem_wr = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
                d.use_a  = 1'b1;
                d.src_a  = ad1[3:2];
                d.use_b  = 1'b1;
                d.src_b  = ad1[1:0];
                d.rd     = ad1[3:2];
                d.reg_wr = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, EX-issue and writeback signals of the decode stage bundled as one interface.
interface id_stage_if;
    import cpu_isa_pkg::*;

    logic [2:0]        in_opcode;
    logic [4:0]        in_ad1;
    logic [DATA_W-1:0] in_imm;
    logic              in_valid;
    logic              stall;
    logic              halt;

    logic              ex_ready;
    logic              ex_valid;
    logic [2:0]        ex_opcode;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic              ex_mem_wr;

    logic              wb_en;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_opcode, in_ad1, in_imm, in_valid, ex_ready, wb_en, wb_addr, wb_data,
        input  stall, halt, ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm,
               ex_reg_wr, ex_mem_rd, ex_mem_wr
    );

    modport slave (
        input  in_opcode, in_ad1, in_imm, in_valid, ex_ready, wb_en, wb_addr, wb_data,
        output stall, halt, ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm,
               ex_reg_wr, ex_mem_rd, ex_mem_wr
    );

endinterface

// File: rtl/id_regfile.sv
// 4x8 register file, two read ports and one write port; a read of the register
// being written this cycle returns the incoming data.
module id_regfile
    import cpu_isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ra_addr_i,
    input  logic [REG_W-1:0]  rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o = (we_i && (wa_i == ra_addr_i)) ? wd_i : regs_q[ra_addr_i];
    assign rb_data_o = (we_i && (wa_i == rb_addr_i)) ? wd_i : regs_q[rb_addr_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage: 2-entry instruction queue, per-register pending-write scoreboard,
// register read with writeback bypass, and registered issue towards EX.
module id_stage
    import cpu_isa_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    instr_t            fifo_q [QDEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [1:0]        pend_q [NREG];
    logic [1:0]        pend_d [NREG];
    logic              halt_q, halt_d;
    ex_t               ex_q, ex_d;

    instr_t            beat, head;
    dec_t              hd;
    logic              beat_valid, head_valid;
    logic [NREG-1:0]   src_blocked, sb_inc, sb_dec;
    logic              hazard, issue, issue_hlt, push, pop, sb_overflow;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              unused_ad1_msb;

    assign unused_ad1_msb = bus.in_ad1[4];

    // The immediate is zeroed on entry for 1-byte ops so a floating in_imm never reaches EX.
    always_comb begin
        beat.opcode = bus.in_opcode;
        beat.ad1    = bus.in_ad1[3:0];
        beat.imm    = has_imm(bus.in_opcode) ? bus.in_imm : '0;
        beat_valid  = bus.in_valid && !halt_q;
        head_valid  = (count_q != 2'd0) || beat_valid;
        head        = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : beat;
        hd          = decode(head.opcode, head.ad1);
    end

    // A lone pending write that retires this very cycle is not a hazard: the
    // regfile write-through hands the op the value being written back.
    always_comb begin
        src_blocked = '0;
        for (int i = 0; i < NREG; i++) begin
            src_blocked[i] = (pend_q[i] != 2'd0) &&
                !((pend_q[i] == 2'd1) && bus.wb_en && (bus.wb_addr == REG_W'(i)));
        end
        hazard    = (hd.use_a && src_blocked[hd.src_a]) || (hd.use_b && src_blocked[hd.src_b]);
        issue     = head_valid && bus.ex_ready && !halt_q && !hazard;
        issue_hlt = issue && hd.is_hlt;
        push      = beat_valid && !issue_hlt && ((count_q != 2'd0) || !issue);
        pop       = issue && (count_q != 2'd0);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (issue_hlt) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
        halt_d = halt_q || issue_hlt;
    end

    always_comb begin
        sb_inc      = '0;
        sb_dec      = '0;
        sb_overflow = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            sb_inc[i] = issue && hd.reg_wr && (hd.rd == REG_W'(i));
            sb_dec[i] = bus.wb_en && (bus.wb_addr == REG_W'(i));
            pend_d[i] = pend_q[i];
            if (sb_inc[i] && !sb_dec[i]) begin
                pend_d[i] = pend_q[i] + 2'd1;
                if (pend_q[i] == 2'd3) sb_overflow = 1'b1;
            end else if (sb_dec[i] && !sb_inc[i] && (pend_q[i] != 2'd0)) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
    end

    always_comb begin
        ex_d = '0;
        if (issue && !hd.is_hlt) begin
            ex_d.valid  = 1'b1;
            ex_d.opcode = head.opcode;
            ex_d.rd     = hd.rd;
            ex_d.a      = hd.use_a ? rdata_a : '0;
            ex_d.b      = hd.use_b ? rdata_b : '0;
            ex_d.imm    = head.imm;
            ex_d.reg_wr = hd.reg_wr;
            ex_d.mem_rd = hd.mem_rd;
            ex_d.mem_wr = hd.mem_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            halt_q   <= 1'b0;
            ex_q     <= '0;
            for (int i = 0; i < NREG; i++) pend_q[i] <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halt_q   <= halt_d;
            ex_q     <= ex_d;
            for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
            if (push) fifo_q[wr_ptr_q] <= beat;
        end
    end

    id_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_addr_i (hd.src_a),
        .rb_addr_i (hd.src_b),
        .ra_data_o (rdata_a),
        .rb_data_o (rdata_b),
        .we_i      (bus.wb_en),
        .wa_i      (bus.wb_addr),
        .wd_i      (bus.wb_data)
    );

    assign bus.stall     = (count_q != 2'd0);
    assign bus.halt      = halt_q;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_opcode = ex_q.opcode;
    assign bus.ex_rd     = ex_q.rd;
    assign bus.ex_a      = ex_q.a;
    assign bus.ex_b      = ex_q.b;
    assign bus.ex_imm    = ex_q.imm;
    assign bus.ex_reg_wr = ex_q.reg_wr;
    assign bus.ex_mem_rd = ex_q.mem_rd;
    assign bus.ex_mem_wr = ex_q.mem_wr;

    // Fetch never sends into a full queue, and no register ever has four writes in flight.
    assert property (@(posedge clk) disable iff (rst) !(beat_valid && (count_q == 2'd2)));
    assert property (@(posedge clk) disable iff (rst) !sb_overflow);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a table of single-issue vectors plus
// hand-written hazard, back-pressure, halt and reset sequences.
module tb_id_stage;
    import cpu_isa_pkg::*;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] ad1;
        logic [7:0] imm;
        logic [1:0] eRd;
        logic [7:0] eA;
        logic [7:0] eB;
        logic [7:0] eImm;
        logic       eRegWr;
        logic       eMemRd;
        logic       eMemWr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [7];

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [2:0] op, input logic [4:0] ad1, input logic [7:0] imm,
                                   input logic [1:0] eRd, input logic [7:0] eA, input logic [7:0] eB,
                                   input logic [7:0] eImm, input logic eRegWr, input logic eMemRd,
                                   input logic eMemWr);
        vec_t v;
        v = {op, ad1, imm, eRd, eA, eB, eImm, eRegWr, eMemRd, eMemWr};
        return v;
    endfunction

    function automatic logic [32:0] mkEx(input logic v, input logic [2:0] op, input logic [1:0] rd,
                                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                                         input logic rw, input logic mr, input logic mw);
        return {v, op, rd, a, b, imm, rw, mr, mw};
    endfunction

    function automatic logic [32:0] exActual();
        return {bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_a, bus.ex_b, bus.ex_imm,
                bus.ex_reg_wr, bus.ex_mem_rd, bus.ex_mem_wr};
    endfunction

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle just after it.
    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] ad1, input logic [7:0] imm,
                                 input logic valid, input logic rdy, input logic wbEn,
                                 input logic [1:0] wbAddr, input logic [7:0] wbData);
        bus.in_opcode = op;
        bus.in_ad1    = ad1;
        bus.in_imm    = imm;
        bus.in_valid  = valid;
        bus.ex_ready  = rdy;
        bus.wb_en     = wbEn;
        bus.wb_addr   = wbAddr;
        bus.wb_data   = wbData;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, rdy, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_opcode = OP_NOP;
        bus.in_ad1    = '0;
        bus.in_imm    = '0;
        bus.in_valid  = 1'b0;
        bus.ex_ready  = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;

        // Vectors assume R0..R3 = 11,22,33,44 and that no earlier entry's destination is sourced later.
        vecs[0] = mkVec(OP_STO, 5'b00010, 8'h80, 2'd0, 8'h33, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
        vecs[1] = mkVec(OP_ADD, 5'b00110, 8'hxx, 2'd1, 8'h22, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[2] = mkVec(OP_SUB, 5'b01100, 8'h05, 2'd3, 8'h44, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[3] = mkVec(OP_AND, 5'b11010, 8'hxx, 2'd2, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[4] = mkVec(OP_NOP, 5'b10101, 8'hxx, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[5] = mkVec(OP_LDA, 5'b00000, 8'hC3, 2'd0, 8'h00, 8'h00, 8'hC3, 1'b1, 1'b1, 1'b0);
        vecs[6] = mkVec(OP_LDO, 5'b11100, 8'hFF, 2'd0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

        doReset();
        checkOutput("reset ex", exActual(), 33'h0);
        checkOutput("reset stall", {32'h0, bus.stall}, 33'h0);
        checkOutput("reset halt", {32'h0, bus.halt}, 33'h0);

        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 8'h11);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 8'h22);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd2, 8'h33);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 8'h44);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ad1, vecs[i].imm, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
            checkOutput($sformatf("vec%0d ex", i), exActual(),
                        mkEx(1'b1, vecs[i].op, vecs[i].eRd, vecs[i].eA, vecs[i].eB, vecs[i].eImm,
                             vecs[i].eRegWr, vecs[i].eMemRd, vecs[i].eMemWr));
            checkOutput($sformatf("vec%0d stall", i), {32'h0, bus.stall}, 33'h0);
        end
        idle(1'b1);
        checkOutput("vec idle ex", exActual(), 33'h0);

        // LDO with no hazard: one-cycle latency to EX.
        doReset();
        applyStimulus(OP_LDO, 5'b00001, 8'h5A, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("ldo ex", exActual(), mkEx(1'b1, OP_LDO, 2'd1, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0));
        checkOutput("ldo stall", {32'h0, bus.stall}, 33'h0);
        idle(1'b1);
        checkOutput("ldo after", {32'h0, bus.ex_valid}, 33'h0);

        // RAW hazard on r2 resolved by a writeback bypass.
        doReset();
        applyStimulus(OP_LDA, 5'b00010, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("lda ex", exActual(), mkEx(1'b1, OP_LDA, 2'd2, 8'h00, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0));
        applyStimulus(OP_ADD, 5'b01000, 8'hxx, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("raw stall0", {32'h0, bus.stall}, 33'h1);
        checkOutput("raw exv0", {32'h0, bus.ex_valid}, 33'h0);
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            checkOutput($sformatf("raw stall%0d", i + 1), {32'h0, bus.stall}, 33'h1);
            checkOutput($sformatf("raw exv%0d", i + 1), {32'h0, bus.ex_valid}, 33'h0);
        end
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd2, 8'h33);
        checkOutput("raw add ex", exActual(), mkEx(1'b1, OP_ADD, 2'd2, 8'h33, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        checkOutput("raw stall end", {32'h0, bus.stall}, 33'h0);

        // Hazard plus a trailing beat: queue fills to two and drains in order.
        doReset();
        applyStimulus(OP_LDA, 5'b00001, 8'h20, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_ADD, 5'b00101, 8'hxx, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("full stall1", {32'h0, bus.stall}, 33'h1);
        applyStimulus(OP_LDO, 5'b00000, 8'h07, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("full stall2", {32'h0, bus.stall}, 33'h1);
        checkOutput("full exv", {32'h0, bus.ex_valid}, 33'h0);
        idle(1'b1);
        checkOutput("full hold", {32'h0, bus.stall}, 33'h1);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44);
        checkOutput("drain add", exActual(), mkEx(1'b1, OP_ADD, 2'd1, 8'h44, 8'h44, 8'h00, 1'b1, 1'b0, 1'b0));
        checkOutput("drain stall1", {32'h0, bus.stall}, 33'h1);
        idle(1'b1);
        checkOutput("drain ldo", exActual(), mkEx(1'b1, OP_LDO, 2'd0, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0));
        checkOutput("drain stall0", {32'h0, bus.stall}, 33'h0);
        idle(1'b1);
        checkOutput("drain idle", {32'h0, bus.ex_valid}, 33'h0);

        // EX back-pressure for three cycles.
        doReset();
        applyStimulus(OP_LDO, 5'b00011, 8'h9C, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("bp stall", {32'h0, bus.stall}, 33'h1);
        checkOutput("bp exv0", {32'h0, bus.ex_valid}, 33'h0);
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            checkOutput($sformatf("bp exv%0d", i + 1), {32'h0, bus.ex_valid}, 33'h0);
        end
        idle(1'b1);
        checkOutput("bp issue", exActual(), mkEx(1'b1, OP_LDO, 2'd3, 8'h00, 8'h00, 8'h9C, 1'b1, 1'b0, 1'b0));
        checkOutput("bp stall end", {32'h0, bus.stall}, 33'h0);

        // HLT with a NOP queued behind it.
        doReset();
        applyStimulus(OP_HLT, 5'b00000, 8'hxx, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_NOP, 5'b00000, 8'hxx, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("hlt queued", {32'h0, bus.stall}, 33'h1);
        idle(1'b1);
        checkOutput("hlt halt", {32'h0, bus.halt}, 33'h1);
        checkOutput("hlt exv", {32'h0, bus.ex_valid}, 33'h0);
        checkOutput("hlt flushed", {32'h0, bus.stall}, 33'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_LDO, 5'b00001, 8'h66, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
            checkOutput($sformatf("halted exv%0d", i), {32'h0, bus.ex_valid}, 33'h0);
            checkOutput($sformatf("halted halt%0d", i), {32'h0, bus.halt}, 33'h1);
            checkOutput($sformatf("halted stall%0d", i), {32'h0, bus.stall}, 33'h0);
        end
        doReset();
        checkOutput("hlt cleared", {32'h0, bus.halt}, 33'h0);
        applyStimulus(OP_LDO, 5'b00001, 8'h11, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("hlt resume", exActual(), mkEx(1'b1, OP_LDO, 2'd1, 8'h00, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0));

        // Reset with a full queue and two writes pending on r3.
        doReset();
        applyStimulus(OP_LDO, 5'b00011, 8'h01, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_NOP, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 8'hAB);
        applyStimulus(OP_LDO, 5'b00011, 8'h02, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_LDO, 5'b00011, 8'h03, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_LDO, 5'b00000, 8'h04, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(OP_LDO, 5'b00001, 8'h05, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("rst full", {32'h0, bus.stall}, 33'h1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        checkOutput("rst stall", {32'h0, bus.stall}, 33'h0);
        checkOutput("rst halt", {32'h0, bus.halt}, 33'h0);
        checkOutput("rst ex", exActual(), 33'h0);
        applyStimulus(OP_ADD, 5'b01111, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("rst sb clear", exActual(), mkEx(1'b1, OP_ADD, 2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        applyStimulus(OP_LDO, 5'b00011, 8'h3C, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("rst ldo r3", exActual(), mkEx(1'b1, OP_LDO, 2'd3, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0));
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
